// File: rtl/fft_r22sdf_bitrev_if.sv
// Sample stream bundle for the R2^2SDF bit-reversal reorder buffer.
// The last_o signal is present only when FFT_BITREV_LAST_EN is defined.
interface fft_r22sdf_bitrev_if #(
  parameter int DATA_WIDTH = 25,
  parameter int N          = 1024
);
  localparam int LOG2N = $clog2(N);

  logic                         valid_i;
  logic signed [DATA_WIDTH-1:0] x_re_i;
  logic signed [DATA_WIDTH-1:0] x_im_i;
  logic                         valid_o;
  logic signed [DATA_WIDTH-1:0] z_re_o;
  logic signed [DATA_WIDTH-1:0] z_im_o;
  logic [LOG2N-1:0]             idx_o;
`ifdef FFT_BITREV_LAST_EN
  logic                         last_o;
`endif

  modport slave (
    input  valid_i, x_re_i, x_im_i,
    output valid_o, z_re_o, z_im_o, idx_o
`ifdef FFT_BITREV_LAST_EN
    , output last_o
`endif
  );

  modport master (
    output valid_i, x_re_i, x_im_i,
    input  valid_o, z_re_o, z_im_o, idx_o
`ifdef FFT_BITREV_LAST_EN
    , input last_o
`endif
  );
endinterface

// File: rtl/fft_r22sdf_bitrev.sv
// Ping-pong reorder buffer: bit-reversed FFT frames in, natural-order gap-free bursts out.
// Optional last_o flag enabled by defining FFT_BITREV_LAST_EN.
module fft_r22sdf_bitrev #(
  parameter int DATA_WIDTH = 25,
  parameter int N          = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_n,
  fft_r22sdf_bitrev_if.slave    bus
);
  localparam int LOG2N = $clog2(N);
  localparam int W     = 2 * DATA_WIDTH;
  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

  typedef enum logic {IDLE, READ} state_t;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
    return r;
  endfunction

  logic [W-1:0]     mem [2][N];
  logic [LOG2N-1:0] wr_cnt;
  logic             wr_bank;
  logic             done;
  logic             done_bank;

  // Write side: counter, bank select and the one-cycle frame-done pulse
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      wr_cnt    <= '0;
      wr_bank   <= 1'b0;
      done      <= 1'b0;
      done_bank <= 1'b0;
    end else begin
      done <= 1'b0;
      if (bus.valid_i) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (wr_cnt == LAST_IDX) begin
          wr_bank   <= ~wr_bank;
          done      <= 1'b1;
          done_bank <= wr_bank;
        end
      end
    end
  end

  // Bank storage is deliberately left unreset
  always_ff @(posedge clk_i) begin
    if (rst_n && bus.valid_i) mem[wr_bank][bitrev(wr_cnt)] <= {bus.x_re_i, bus.x_im_i};
  end

  state_t           state, state_nxt;
  logic [LOG2N-1:0] rd_cnt, rd_cnt_nxt;
  logic             rd_bank, rd_bank_nxt;
  logic             rd_en;
  logic [W-1:0]     rd_word;

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state   <= IDLE;
      rd_cnt  <= '0;
      rd_bank <= 1'b0;
    end else begin
      state   <= state_nxt;
      rd_cnt  <= rd_cnt_nxt;
      rd_bank <= rd_bank_nxt;
    end
  end

  // A frame-done on the final read cycle chains the next burst without a bubble
  always_comb begin
    state_nxt   = state;
    rd_cnt_nxt  = rd_cnt;
    rd_bank_nxt = rd_bank;
    case (state)
      IDLE: begin
        if (done) begin
          state_nxt   = READ;
          rd_cnt_nxt  = '0;
          rd_bank_nxt = done_bank;
        end
      end
      READ: begin
        if (rd_cnt == LAST_IDX) begin
          rd_cnt_nxt = '0;
          if (done) rd_bank_nxt = done_bank;
          else      state_nxt   = IDLE;
        end else begin
          rd_cnt_nxt = rd_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_en = (state == READ);
  end

  assign rd_word = mem[rd_bank][rd_cnt];

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      bus.valid_o <= 1'b0;
      bus.z_re_o  <= '0;
      bus.z_im_o  <= '0;
      bus.idx_o   <= '0;
    end else begin
      bus.valid_o <= rd_en;
      if (rd_en) begin
        {bus.z_re_o, bus.z_im_o} <= rd_word;
        bus.idx_o                <= rd_cnt;
      end
    end
  end

`ifdef FFT_BITREV_LAST_EN
  always_ff @(posedge clk_i) begin
    if (!rst_n) bus.last_o <= 1'b0;
    else        bus.last_o <= rd_en && (rd_cnt == LAST_IDX);
  end
`endif
endmodule

// File: tb/tb_fft_r22sdf_bitrev.sv
// Directed bench for the reorder buffer: N=8 ordering, gaps, back-to-back, reset, N=4 extremes.
module tb_fft_r22sdf_bitrev;
  logic clk_i = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk_i = ~clk_i;

  fft_r22sdf_bitrev_if #(.DATA_WIDTH(25), .N(8)) b8 ();
  fft_r22sdf_bitrev_if #(.DATA_WIDTH(8),  .N(4)) b4 ();

  fft_r22sdf_bitrev #(.DATA_WIDTH(25), .N(8)) dut8 (.clk_i(clk_i), .rst_n(rst_n), .bus(b8));
  fft_r22sdf_bitrev #(.DATA_WIDTH(8),  .N(4)) dut4 (.clk_i(clk_i), .rst_n(rst_n), .bus(b4));

  typedef struct {
    int in_re;
    int in_im;
    int exp_re;
    int exp_im;
    int exp_idx;
    bit exp_last;
  } vec_t;

  vec_t tbl [24];
  int   checks = 0;
  int   errors = 0;
  bit   e_seen;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int rev3(input int k);
    logic [2:0] kk;
    kk = k[2:0];
    return int'({kk[0], kk[1], kk[2]});
  endfunction

  task automatic chk8_bin(input int j);
    chk("valid8", longint'(b8.valid_o), 1);
    chk("re8", longint'(b8.z_re_o), longint'(tbl[j].exp_re));
    chk("im8", longint'(b8.z_im_o), longint'(tbl[j].exp_im));
    chk("idx8", longint'(b8.idx_o), longint'(tbl[j].exp_idx));
`ifdef FFT_BITREV_LAST_EN
    chk("last8", longint'(b8.last_o), longint'(tbl[j].exp_last));
`endif
  endtask

  // Streams nfr frames from table frame 'first'; checks the whole burst timing.
  task automatic run8(input int first, input int nfr, input bit gapped);
    e_seen = 1'b0;
    fork
      begin
        for (int i = first * 8; i < (first + nfr) * 8; i++) begin
          @(negedge clk_i);
          b8.valid_i = 1'b1;
          b8.x_re_i  = 25'(tbl[i].in_re);
          b8.x_im_i  = 25'(tbl[i].in_im);
          @(posedge clk_i);
          if (i == first * 8 + 7) e_seen = 1'b1;
          if (gapped) begin
            @(negedge clk_i);
            b8.valid_i = 1'b0;
            @(posedge clk_i);
          end
        end
        @(negedge clk_i);
        b8.valid_i = 1'b0;
      end
      begin
        int to = 0;
        while (!e_seen && to < 500) begin
          @(negedge clk_i);
          to++;
        end
        chk("frame_end_seen", longint'(e_seen), 1);
        chk("valid8_E", longint'(b8.valid_o), 0);
        @(negedge clk_i);
        chk("valid8_E1", longint'(b8.valid_o), 0);
        for (int j = first * 8; j < (first + nfr) * 8; j++) begin
          @(negedge clk_i);
          chk8_bin(j);
        end
        @(negedge clk_i);
        chk("valid8_after", longint'(b8.valid_o), 0);
      end
    join
  endtask

  initial begin
    int exp4_re [4];
    int exp4_im [4];
    int in4_re  [4];

    for (int f = 0; f < 3; f++)
      for (int k = 0; k < 8; k++) begin
        tbl[f*8+k].in_re    = 100 * f + rev3(k);
        tbl[f*8+k].in_im    = -(100 * f + rev3(k));
        tbl[f*8+k].exp_re   = 100 * f + k;
        tbl[f*8+k].exp_im   = -(100 * f + k);
        tbl[f*8+k].exp_idx  = k;
        tbl[f*8+k].exp_last = (k == 7);
      end
    in4_re  = '{127, -128, 0, 1};
    exp4_re = '{127, 0, -128, 1};
    exp4_im = '{10, 12, 11, 13};

    b8.valid_i = 1'b0; b8.x_re_i = '0; b8.x_im_i = '0;
    b4.valid_i = 1'b0; b4.x_re_i = '0; b4.x_im_i = '0;
    repeat (3) @(negedge clk_i);
    chk("rst_valid8", longint'(b8.valid_o), 0);
    chk("rst_re8", longint'(b8.z_re_o), 0);
    chk("rst_im8", longint'(b8.z_im_o), 0);
    chk("rst_idx8", longint'(b8.idx_o), 0);
    chk("rst_valid4", longint'(b4.valid_o), 0);
`ifdef FFT_BITREV_LAST_EN
    chk("rst_last8", longint'(b8.last_o), 0);
`endif
    rst_n = 1'b1;
    @(negedge clk_i);

    run8(0, 1, 1'b0);
    repeat (2) @(negedge clk_i);
    run8(0, 1, 1'b1);
    repeat (2) @(negedge clk_i);
    run8(0, 3, 1'b0);
    repeat (2) @(negedge clk_i);

    // Reset while frame 0 bursts and frame 1 is 5 samples in
    for (int i = 0; i < 13; i++) begin
      b8.valid_i = 1'b1;
      b8.x_re_i  = 25'(tbl[i].in_re);
      b8.x_im_i  = 25'(tbl[i].in_im);
      @(negedge clk_i);
    end
    chk8_bin(3);
    rst_n = 1'b0;
    b8.x_re_i = 25'(999);
    b8.x_im_i = 25'(999);
    @(negedge clk_i);
    chk("rstmid_valid8", longint'(b8.valid_o), 0);
    chk("rstmid_re8", longint'(b8.z_re_o), 0);
    chk("rstmid_im8", longint'(b8.z_im_o), 0);
    chk("rstmid_idx8", longint'(b8.idx_o), 0);
    rst_n = 1'b1;
    b8.valid_i = 1'b0;
    run8(1, 1, 1'b0);
    repeat (2) @(negedge clk_i);

    // N=4, 8-bit signed extremes
    for (int k = 0; k < 4; k++) begin
      b4.valid_i = 1'b1;
      b4.x_re_i  = 8'(in4_re[k]);
      b4.x_im_i  = 8'(10 + k);
      @(negedge clk_i);
    end
    b4.valid_i = 1'b0;
    chk("valid4_E", longint'(b4.valid_o), 0);
    @(negedge clk_i);
    chk("valid4_E1", longint'(b4.valid_o), 0);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk_i);
      chk("valid4", longint'(b4.valid_o), 1);
      chk("re4", longint'(b4.z_re_o), longint'(exp4_re[j]));
      chk("im4", longint'(b4.z_im_o), longint'(exp4_im[j]));
      chk("idx4", longint'(b4.idx_o), longint'(j));
`ifdef FFT_BITREV_LAST_EN
      chk("last4", longint'(b4.last_o), longint'(j == 3));
`endif
    end
    @(negedge clk_i);
    chk("valid4_after", longint'(b4.valid_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fft_r22sdf_bitrev.md
# fft_r22sdf_bitrev

Output reorder buffer for the R2²SDF FFT pipeline. The last butterfly stage emits each frame in bit-reversed frequency order, one complex sample per accepted cycle. This block buffers each frame in a ping-pong memory and replays it in natural order (bin 0 … N-1) as a gap-free burst. It sits directly after the final BF II stage and feeds downstream consumers, which have no backpressure.

## Interface
- DATA_WIDTH, 25, width of each real/imaginary component (signed)
- N, 1024, frame length; power of 2, N ≥ 4; LOG2N = $clog2(N) is derived internally
- clk_i  in  1  clock; all logic on rising edge
- rst_n  in  1  reset: synchronous, active-low; clock clk_i
- valid_i  in  1  input sample valid; gaps allowed between and within frames
- x_re_i, x_im_i  in  DATA_WIDTH each  input sample, bit-reversed order
- valid_o  out  1  output sample valid
- z_re_o, z_im_o  out  DATA_WIDTH each  output sample, natural order
- idx_o  out  LOG2N  frequency bin of the current output
- last_o  out  1  high with bin N-1; present only with FFT_BITREV_LAST_EN

## Operation
- Storage: two banks of N × 2·DATA_WIDTH, synchronous-read RAM. Bank contents are not reset.
- Write side:
  - wr_cnt (LOG2N bits) counts accepted samples; wr_bank selects the bank.
  - On valid_i, write {x_re_i, x_im_i} to wr_bank at address bitrev(wr_cnt), then increment wr_cnt.
  - When wr_cnt == N-1 is accepted: wr_cnt wraps to 0, wr_bank toggles, and a frame-done pulse is sent to the reader with the filled bank index.
- Reader FSM, two states:
  - IDLE: on frame-done, latch rd_bank, set rd_cnt = 0, go to READ.
  - READ: issue a read of rd_bank at rd_cnt every cycle. At rd_cnt == N-1 go to IDLE, unless frame-done arrives that same cycle; then reload rd_bank, set rd_cnt = 0 and stay in READ (back-to-back).
- Output: the registered RAM data appears one cycle after the read is issued. valid_o and idx_o are pipelined alongside it.
- Overlap: input rate is at most 1 sample/cycle, so writing a frame takes ≥ N cycles, which equals the read time. The reader therefore always finishes a bank before the writer re-enters it. No overrun is possible, and no flag is provided.
- Arithmetic: data passes through unmodified; there is no width growth.

## Timing
- Reset values: valid_o=0, z_re_o=0, z_im_o=0, idx_o=0, last_o=0. Internally wr_cnt=0, wr_bank=0, FSM=IDLE, rd_cnt=0.
- Latency:
  - Last input sample of a frame accepted at edge E.
  - Reader issues the read for bin 0 at edge E+1.
  - valid_o is high with bin 0 after edge E+2.
  - Bin k is output after edge E+2+k. The burst is N consecutive cycles; last_o is high with bin N-1 only.
- Back-to-back frames with valid_i held high give continuous valid_o with no bubble between bursts.
- Input gaps inside a frame only delay E; they never affect the output burst.
- Reset mid-frame discards the partial write frame and aborts any read burst. valid_o is 0 from the first edge with rst_n low. The next frame is written to bank 0 starting at wr_cnt 0.
- valid_i is ignored while rst_n is low.

## Configuration
- FFT_BITREV_LAST_EN:
  - Defined: last_o port exists and is registered in the output pipeline, reset to 0.
  - Undefined: the port and its logic are absent; all other behaviour is identical.

## Test plan
- N=8 ordering: one frame with valid_i continuous, sample k = (re=bitrev(k), im=-bitrev(k)), i.e. re sequence 0,4,2,6,1,5,3,7 -> after E+2, z_re_o = 0..7, z_im_o = 0..-7, idx_o = 0..7, last_o only on idx 7.
- Gapped input: same frame with valid_i toggling 1,0,1,0… -> identical output burst, contiguous 8 cycles, starting exactly 2 edges after the last accepted sample.
- Back-to-back frames: three frames streamed with valid_i constantly 1, frame f sample re = 100·f + bitrev(k) -> 24 contiguous valid_o cycles, values 0..7, 100..107, 200..207, no bubble.
- Reset mid-operation: assert rst_n=0 after 5 samples of frame 2 while frame 1 is bursting -> valid_o=0 and all outputs 0 the next cycle. A fresh full frame afterwards reads out correctly from bank 0.
- Boundary N=4, DATA_WIDTH=8: frame re = 127,-128,0,1 in bit-reversed positions -> natural output re = 127,0,-128,1 (bitrev of indices 0,1,2,3 is 0,2,1,3); signed extremes are preserved.
- Macro: build without FFT_BITREV_LAST_EN -> last_o port absent and test 1 still passes.
